// File: rtl/daq_pkg.sv
// Shared definitions for the DAQ bin scheduler: FSM encoding, word width and
// the round-robin search used by the readout arbiter.
package daq_pkg;

  localparam int DAQ_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } daq_state_e;

  // Returns {found, index} of the first set request searching upward from
  // last+1 with wraparound over n channels (n <= 8).
  function automatic logic [3:0] rr_next(input logic [7:0] req,
                                         input logic [2:0] last,
                                         input int n);
    logic [3:0] res;
    int idx;
    res = 4'd0;
    // Walk from the farthest candidate back to the nearest so the nearest wins.
    for (int k = n; k >= 1; k--) begin
      idx = (int'(last) + k) % n;
      if (req[idx]) res = {1'b1, idx[2:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/daq_rr_arbiter.sv
// Round-robin slot selector; combinational, the last_grant pointer lives in
// the scheduler's output stage.
module daq_rr_arbiter
  import daq_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0] req,
  input  logic [2:0]     last_grant,
  input  logic           load,
  output logic [2:0]     grant_idx,
  output logic           grant_any
);

  logic [7:0] req_ext;
  logic [3:0] pick;

  always_comb begin
    req_ext = '0;
    req_ext[NCH-1:0] = req;
    pick = rr_next(req_ext, last_grant, NCH);
    grant_idx = pick[2:0];
    grant_any = load & pick[3];
  end

endmodule

// File: rtl/daq_bin_scheduler.sv
// Bin-boundary tick generator, run/drain sequencer and per-channel one-deep
// slots arbitrated round-robin onto a single valid/ready readout stream.
module daq_bin_scheduler
  import daq_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = DAQ_WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [31:0]      binsize,
  input  logic             clr_ovf,
  input  logic [NCH-1:0]   ch_valid,
  input  logic [NCH*W-1:0] ch_data,
  input  logic             out_ready,
  output logic             bin_tick,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [2:0]       out_ch,
  output logic             busy,
  output logic [NCH-1:0]   overflow
);

  daq_state_e state_reg, state_next;
  logic [31:0]    timer_reg;
  logic [31:0]    binsize_q;
  logic [NCH-1:0] slot_full_reg;
  logic [W-1:0]   slot_data_reg [NCH];
  logic           out_valid_reg;
  logic [W-1:0]   out_data_reg;
  logic [2:0]     out_ch_reg;
  logic [2:0]     last_grant_reg;
  logic [NCH-1:0] overflow_reg;

  logic           load;
  logic [2:0]     grant_idx;
  logic           grant_any;
  logic [NCH-1:0] take;
  logic [NCH-1:0] capture;
  logic [NCH-1:0] drop;
  logic [W-1:0]   sel_data;

  assign load = ~out_valid_reg | out_ready;

  daq_rr_arbiter #(.NCH(NCH)) u_arb (
    .req        (slot_full_reg),
    .last_grant (last_grant_reg),
    .load       (load),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (!enable) state_next = DRAIN;
      DRAIN:   if (slot_full_reg == '0 && !out_valid_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // The tick is decoded from registered state so it is gone as soon as the
  // FSM leaves RUN, including a boundary coinciding with the DRAIN entry.
  assign bin_tick = (state_reg == RUN) && (timer_reg == binsize_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_reg <= '0;
      binsize_q <= '0;
    end else begin
      if (state_reg == IDLE && enable) binsize_q <= binsize;
      if (state_reg != RUN)            timer_reg <= '0;
      else if (bin_tick)               timer_reg <= '0;
      else                             timer_reg <= timer_reg + 32'd1;
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NCH; i++)
      if (grant_idx == 3'(i)) sel_data = slot_data_reg[i];
  end

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_slot
      // A slot emptied onto the output this cycle can take a new word at once.
      assign take[gi]    = grant_any && (grant_idx == 3'(gi));
      assign capture[gi] = ch_valid[gi] & (~slot_full_reg[gi] | take[gi]);
      assign drop[gi]    = ch_valid[gi] & slot_full_reg[gi] & ~take[gi];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          slot_full_reg[gi] <= 1'b0;
          slot_data_reg[gi] <= '0;
        end else if (capture[gi]) begin
          slot_full_reg[gi] <= 1'b1;
          slot_data_reg[gi] <= ch_data[gi*W +: W];
        end else if (take[gi]) begin
          slot_full_reg[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_ch_reg     <= '0;
      last_grant_reg <= 3'(NCH - 1);
      overflow_reg   <= '0;
    end else begin
      overflow_reg <= drop | (overflow_reg & ~{NCH{clr_ovf}});
      if (load) begin
        if (grant_any) begin
          out_valid_reg  <= 1'b1;
          out_data_reg   <= sel_data;
          out_ch_reg     <= grant_idx;
          last_grant_reg <= grant_idx;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;
  assign busy      = (state_reg != IDLE);
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_daq_bin_scheduler.sv
// Scoreboard bench for daq_bin_scheduler: a transaction-level model predicts
// each word leaving the block; a monitor checks outputs every cycle.
module tb_daq_bin_scheduler;

  localparam int NCH = 4;
  localparam int W   = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [31:0]      binsize;
  logic             clr_ovf;
  logic [NCH-1:0]   ch_valid;
  logic [NCH*W-1:0] ch_data;
  logic             out_ready;
  logic             bin_tick;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [2:0]       out_ch;
  logic             busy;
  logic [NCH-1:0]   overflow;

  daq_bin_scheduler #(.NCH(NCH), .W(W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .binsize(binsize), .clr_ovf(clr_ovf),
    .ch_valid(ch_valid), .ch_data(ch_data), .out_ready(out_ready),
    .bin_tick(bin_tick), .out_valid(out_valid), .out_data(out_data),
    .out_ch(out_ch), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct { logic [2:0] ch; logic [W-1:0] data; } exp_t;
  exp_t exp_q[$];

  // Reference model: pending words per channel, the word on the output, and
  // a run-cycle counter from which the bin boundaries follow arithmetically.
  int          m_mode;          // 0 idle, 1 run, 2 drain
  longint      m_runcyc;
  longint      m_bsz;
  bit          m_pend [NCH];
  logic [W-1:0] m_pword [NCH];
  bit          m_hv;
  int          m_last;
  logic [NCH-1:0] m_ovf;

  always @(posedge clk or negedge rst) begin : model
    bit found;
    bit pre_empty;
    int pick;
    int c;
    if (!rst) begin
      m_mode = 0; m_runcyc = 0; m_bsz = 0; m_hv = 0; m_last = NCH - 1; m_ovf = '0;
      for (int i = 0; i < NCH; i++) begin m_pend[i] = 0; m_pword[i] = '0; end
      exp_q.delete();
    end else begin
      pre_empty = !m_hv;
      for (int i = 0; i < NCH; i++) if (m_pend[i]) pre_empty = 0;
      if (!m_hv || out_ready) begin
        found = 0; pick = 0;
        for (int k = 1; k <= NCH; k++) begin
          c = (m_last + k) % NCH;
          if (!found && m_pend[c]) begin found = 1; pick = c; end
        end
        if (found) begin
          m_pend[pick] = 0; m_hv = 1; m_last = pick;
          exp_q.push_back('{ch: 3'(pick), data: m_pword[pick]});
        end else m_hv = 0;
      end
      if (clr_ovf) m_ovf = '0;
      for (int i = 0; i < NCH; i++)
        if (ch_valid[i]) begin
          if (m_pend[i]) m_ovf[i] = 1'b1;
          else begin m_pend[i] = 1; m_pword[i] = ch_data[i*W +: W]; end
        end
      case (m_mode)
        0: if (enable) begin m_mode = 1; m_runcyc = 0; m_bsz = longint'(binsize); end
        1: if (!enable) m_mode = 2; else m_runcyc++;
        default: if (pre_empty) m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin : monitor
    if (rst) begin
      chk("bin_tick", bin_tick, (m_mode == 1) && ((m_runcyc % (m_bsz + 1)) == m_bsz));
      chk("busy", busy, m_mode != 0);
      chk("overflow", overflow, m_ovf);
      chk("out_valid", out_valid, m_hv);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL exp_empty: out_valid=1 ch=%0d but no word expected", out_ch);
        end else begin
          chk("out_ch", out_ch, exp_q[0].ch);
          chk("out_data", out_data, exp_q[0].data);
          if (out_ready) begin
            $display("accept ch=%0d data=%08h t=%0t", out_ch, out_data, $time);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
    ch_valid = '0;
    clr_ovf  = 1'b0;
  endtask

  task automatic strobe(input logic [NCH-1:0] m);
    ch_valid = m;
    for (int i = 0; i < NCH; i++) ch_data[i*W +: W] = $urandom;
  endtask

  initial begin : stim
    int nt, cnt, same, g0, g2, prev;
    logic [15:0] seq;
    logic [W-1:0] held;

    rst = 0; enable = 0; binsize = 0; clr_ovf = 0; ch_valid = '0; ch_data = '0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_bin_tick", bin_tick, 0);
    chk("rst_overflow", overflow, 0);
    rst = 1;
    next_cycle();

    // Bin period 5, binsize changed mid-run must not alter it.
    binsize = 4; enable = 1;
    next_cycle();
    nt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 7) binsize = 9;
      if (bin_tick) nt++;
      next_cycle();
    end
    chk("tick_count", nt, 4);

    // All channels together: four back-to-back words in ch0..ch3 order.
    out_ready = 1;
    ch_valid = '1;
    for (int i = 0; i < NCH; i++) ch_data[i*W +: W] = 32'hA0 + i;
    next_cycle();
    seq = 0; cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid && out_ready) begin seq = {seq[11:0], 1'b0, out_ch}; cnt++; end
      next_cycle();
    end
    chk("rr_order", seq, 16'h0123);
    chk("rr_count", cnt, 4);
    chk("rr_no_ovf", overflow, 0);

    // Stall: ch1 fills output and slot, then drops; clear loses to a drop.
    out_ready = 0;
    strobe(4'b0010); next_cycle();
    next_cycle();
    held = out_data;
    strobe(4'b0010); next_cycle();
    strobe(4'b0010); next_cycle();
    strobe(4'b0010); clr_ovf = 1; next_cycle();
    repeat (5) next_cycle();
    chk("stall_hold", out_data, held);
    chk("stall_ovf1", overflow[1], 1);
    out_ready = 1;
    repeat (4) next_cycle();

    // Fairness: ch0 and ch2 request continuously.
    clr_ovf = 1; next_cycle();
    same = 0; g0 = 0; g2 = 0; prev = -1;
    for (int i = 0; i < 14; i++) begin
      if (out_valid) begin
        if (int'(out_ch) == prev) same++;
        if (out_ch == 0) g0++;
        if (out_ch == 2) g2++;
        prev = int'(out_ch);
      end
      if (i < 12) strobe(4'b0101);
      next_cycle();
    end
    chk("fair_repeat", same, 0);
    chk("fair_ch0_served", g0 >= 5, 1);
    chk("fair_ch2_served", g2 >= 5, 1);
    repeat (3) next_cycle();

    // Drain with output plus three slots holding words.
    out_ready = 0;
    strobe(4'b1111); next_cycle();
    next_cycle();
    enable = 0; next_cycle();
    for (int i = 0; i < 6; i++) begin
      chk("drain_busy", busy, 1);
      chk("drain_no_tick", bin_tick, 0);
      enable = (i == 3);
      next_cycle();
    end
    enable = 0;
    out_ready = 1;
    cnt = 0;
    for (int i = 0; i < 20 && busy; i++) begin
      if (out_valid && out_ready) cnt++;
      next_cycle();
    end
    chk("drain_words", cnt, 4);
    chk("drain_idle", busy, 0);

    // Randomised traffic with run/stop, clears and back-pressure.
    for (int i = 0; i < 400; i++) begin
      enable    = ($urandom_range(0, 15) != 0) ? enable : ~enable;
      binsize   = $urandom_range(0, 6);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_ovf   = ($urandom_range(0, 15) == 0);
      strobe(NCH'($urandom));
      next_cycle();
    end

    // Reset in the middle of a stalled transfer.
    enable = 1; out_ready = 0;
    strobe(4'b1110); next_cycle();
    repeat (3) next_cycle();
    chk("pre_rst_valid", out_valid, 1);
    @(posedge clk); #3;
    rst = 0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_tick", bin_tick, 0);
    #1;
    rst = 1;
    enable = 0; out_ready = 1;
    repeat (4) next_cycle();
    chk("post_rst_empty", out_valid, 0);
    strobe(4'b1111); next_cycle();
    cnt = 0;
    while (!out_valid && cnt < 5) begin cnt++; next_cycle(); end
    chk("post_rst_first", out_ch, 0);
    repeat (10) next_cycle();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
